// File: rtl/half_duplex_link_pkg.sv
// Shared definitions for the half-duplex serial link: FSM state encodings,
// default parameter values and the level the line rests at when undriven.
package half_duplex_link_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TURN     = 3'd3,
        RX_WAIT  = 3'd4,
        RX_START = 3'd5,
        RX_DATA  = 3'd6,
        DONE     = 3'd7
    } link_state_e;

    localparam int   DEF_DATA_W       = 8;
    localparam int   DEF_BIT_CYCLES   = 4;
    localparam int   DEF_TURN_CYCLES  = 2;
    localparam int   DEF_TIMEOUT_BITS = 16;
    localparam logic LINE_IDLE        = 1'b1;

    // Counter width that holds the full response timeout without wrapping.
    function automatic int timerWidth(input int bitCycles, input int timeoutBits);
        return $clog2(bitCycles * timeoutBits + 1);
    endfunction

endpackage

// File: rtl/half_duplex_link_bit_timer.sv
// Loadable down-counter; tick_o is high while the count rests at zero, so a
// load of N-1 is acted on by the FSM at the N-th following clock edge.
module half_duplex_link_bit_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/half_duplex_link.sv
// Half-duplex transaction engine: sends one word on a shared pulled-up line,
// releases it for turnaround, then captures the far end's response word.
module half_duplex_link
    import half_duplex_link_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int TURN_CYCLES  = DEF_TURN_CYCLES,
    parameter int TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rx_data,
    output logic              line_out,
    output logic              line_oe,
    input  logic              line_in
);

    localparam int CNT_W = timerWidth(BIT_CYCLES, TIMEOUT_BITS);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] BIT_LOAD    = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD   = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_BITS * BIT_CYCLES);
    localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_W - 1);

    link_state_e       state_q;
    logic [DATA_W-1:0] txShift_q;
    logic [DATA_W-1:0] rxShift_q;
    logic [DATA_W-1:0] rxData_q;
    logic [BIT_W-1:0]  bitCnt_q;
    logic [CNT_W-1:0]  waitCnt_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              lineOut_q;
    logic              lineOe_q;

    logic              lineBit;
    logic              lineLow;
    logic              tick;
    logic              timerLoad;
    logic [CNT_W-1:0]  timerVal;

    // Anything other than a clean 0 (including X/Z) reads as the idle level.
    always_comb begin
        lineBit = LINE_IDLE;
        if (line_in == 1'b0) begin
            lineBit = 1'b0;
        end
    end
    assign lineLow = ~lineBit;

    always_comb begin
        timerLoad = 1'b0;
        timerVal  = BIT_LOAD;
        case (state_q)
            IDLE:                        timerLoad = start;
            TX_START, RX_START, RX_DATA: timerLoad = tick;
            TX_DATA: begin
                timerLoad = tick;
                if (bitCnt_q == LAST_BIT) begin
                    timerVal = TURN_LOAD;
                end
            end
            RX_WAIT: begin
                timerLoad = lineLow;
                timerVal  = HALF_LOAD;
            end
            default: ;
        endcase
    end

    half_duplex_link_bit_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (timerLoad),
        .load_val_i (timerVal),
        .tick_o     (tick)
    );

    // Line drivers and busy follow the state one clock later, so the pin
    // only ever sees flop outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            txShift_q <= '0;
            rxShift_q <= '0;
            rxData_q  <= '0;
            bitCnt_q  <= '0;
            waitCnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            lineOut_q <= LINE_IDLE;
            lineOe_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        txShift_q <= tx_data;
                        bitCnt_q  <= '0;
                        state_q   <= TX_START;
                    end
                end
                TX_START: begin
                    if (tick) state_q <= TX_DATA;
                end
                TX_DATA: begin
                    if (tick) begin
                        if (bitCnt_q == LAST_BIT) begin
                            state_q <= TURN;
                        end else begin
                            txShift_q <= txShift_q >> 1;
                            bitCnt_q  <= bitCnt_q + 1'b1;
                        end
                    end
                end
                TURN: begin
                    if (tick) begin
                        waitCnt_q <= '0;
                        state_q   <= RX_WAIT;
                    end
                end
                // The wait count survives false starts so glitches cannot stretch the timeout.
                RX_WAIT: begin
                    if (lineLow) begin
                        state_q <= RX_START;
                    end else if (waitCnt_q == TIMEOUT_CNT) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        waitCnt_q <= waitCnt_q + 1'b1;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (lineLow) begin
                            bitCnt_q <= '0;
                            state_q  <= RX_DATA;
                        end else begin
                            state_q <= RX_WAIT;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        rxShift_q <= {lineBit, rxShift_q[DATA_W-1:1]};
                        if (bitCnt_q == LAST_BIT) begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            bitCnt_q <= bitCnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!err_q) rxData_q <= rxShift_q;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            lineOe_q  <= (state_q == TX_START) || (state_q == TX_DATA);
            lineOut_q <= (state_q == TX_START) ? 1'b0 :
                         (state_q == TX_DATA)  ? txShift_q[0] : LINE_IDLE;
            busy_q    <= (state_q != IDLE) && (state_q != DONE);
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign rx_data  = rxData_q;
    assign line_out = lineOut_q;
    assign line_oe  = lineOe_q;

endmodule

// File: tb/tb_half_duplex_link.sv
// Directed bench for half_duplex_link: a table of transactions against a
// simple line responder, plus hand-written reset and idle sequences.
module tb_half_duplex_link;

    localparam int W  = 8;
    localparam int BC = 4;
    localparam int TC = 2;
    localparam int TO = 16;

    typedef struct {
        logic [7:0] txWord;
        bit         respond;
        bit         glitch;
        logic [7:0] respWord;
        bit         b2b;
        bit         midStart;
        bit         doneStart;
        bit         expErr;
        logic [7:0] expRx;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] rx_data;
    logic       line_out;
    logic       line_oe;
    logic       respOe = 1'b0;
    logic       respVal = 1'b1;
    wire        lineW;

    int vecCount = 0;
    int missCount = 0;
    vec_t vecs [7];

    // Shared pin: DUT buffer, responder buffer, external pull-up when both release.
    assign lineW = line_oe ? line_out : (respOe ? respVal : 1'b1);

    always #5 clk = ~clk;

    half_duplex_link dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .tx_data  (tx_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rx_data  (rx_data),
        .line_out (line_out),
        .line_oe  (line_oe),
        .line_in  (lineW)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One full transaction; on entry and exit the bench sits on a falling edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        logic [W:0] frame;
        logic [1:0] oeEdge;
        int         b;
        int         doneK;
        int         driveK;
        int         expDoneK;
        bit         seenDone;
        bit         contention;
        logic       errSeen;

        if (!v.b2b) @(negedge clk);
        start   = 1'b1;
        tx_data = v.txWord;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        tx_data = 8'h00;

        frame  = '0;
        oeEdge = '0;
        for (int i = 1; i <= 1 + (W + 1) * BC; i++) begin
            @(negedge clk);
            if (i == 1)
                checkOutput($sformatf("v%0d accept", idx), {29'd0, busy, line_oe, line_out}, 32'h6);
            if (i >= 1 + BC / 2 && ((i - 1 - BC / 2) % BC) == 0) begin
                b = (i - 1 - BC / 2) / BC;
                if (b <= W) frame[b] = lineW;
            end
            if (i == (W + 1) * BC) oeEdge[1] = line_oe;
            if (i == 1 + (W + 1) * BC) oeEdge[0] = line_oe;
            if (v.midStart && i == 1 + 3 * BC) begin
                start   = 1'b1;
                tx_data = 8'hFF;
            end
            if (v.midStart && i == 2 + 3 * BC) begin
                start   = 1'b0;
                tx_data = 8'h00;
            end
        end
        checkOutput($sformatf("v%0d txFrame", idx), {23'd0, frame}, {23'd0, v.txWord, 1'b0});
        checkOutput($sformatf("v%0d oeFall", idx), {30'd0, oeEdge}, 32'h2);

        driveK     = v.glitch ? TC + 8 : TC + 3;
        seenDone   = 1'b0;
        contention = 1'b0;
        doneK      = 0;
        errSeen    = 1'b0;
        for (int k = 1; k <= 200 && !seenDone; k++) begin
            @(negedge clk);
            if (line_oe && respOe) contention = 1'b1;
            if (done) begin
                seenDone = 1'b1;
                doneK    = k;
                errSeen  = err;
            end
            respOe  = 1'b0;
            respVal = 1'b1;
            if (v.respond) begin
                if (v.glitch && k == TC + 2) begin
                    respOe  = 1'b1;
                    respVal = 1'b0;
                end
                if (k >= driveK && k < driveK + BC * (W + 1)) begin
                    respOe  = 1'b1;
                    respVal = (k < driveK + BC) ? 1'b0 : v.respWord[(k - driveK - BC) / BC];
                end
            end
        end
        respOe  = 1'b0;
        respVal = 1'b1;

        expDoneK = v.respond ? driveK + 1 + BC / 2 + W * BC : TC + TO * BC;
        checkOutput($sformatf("v%0d doneSeen", idx), {31'd0, seenDone}, 32'h1);
        checkOutput($sformatf("v%0d doneLatency", idx), doneK, expDoneK);
        checkOutput($sformatf("v%0d err", idx), {31'd0, errSeen}, {31'd0, v.expErr});
        checkOutput($sformatf("v%0d contention", idx), {31'd0, contention}, 32'h0);

        if (v.doneStart) begin
            start   = 1'b1;
            tx_data = 8'hFF;
        end
        @(negedge clk);
        start   = 1'b0;
        tx_data = 8'h00;
        checkOutput($sformatf("v%0d doneEnd", idx), {30'd0, done, busy}, 32'h0);
        checkOutput($sformatf("v%0d rxData", idx), {24'd0, rx_data}, {24'd0, v.expRx});
        if (v.doneStart) begin
            @(negedge clk);
            checkOutput($sformatf("v%0d doneStartIgnored", idx), {30'd0, busy, line_oe}, 32'h0);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit idleBad;

        //          tx     resp  glit  respW  b2b   mid   dStrt err   expRx
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
        vecs[1] = '{8'h5A, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C};
        vecs[2] = '{8'h0F, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF};
        vecs[5] = '{8'hC3, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[6] = '{8'h69, 1'b1, 1'b1, 8'h96, 1'b0, 1'b1, 1'b1, 1'b0, 8'h96};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetValues", {19'd0, line_oe, line_out, busy, done, err, rx_data},
                    {19'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        rst_n = 1'b1;

        idleBad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (line_oe || busy || lineW !== 1'b1) idleBad = 1'b1;
        end
        checkOutput("idle100", {31'd0, idleBad}, 32'h0);

        for (int n = 0; n < 7; n++) applyStimulus(vecs[n], n);

        @(negedge clk);
        start   = 1'b1;
        tx_data = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        tx_data = 8'h00;
        repeat (4 * BC + 2) @(negedge clk);
        checkOutput("bit3Driven", {30'd0, line_oe, line_out}, 32'h2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncRelease", {31'd0, line_oe}, 32'h0);
        checkOutput("asyncResetAll", {19'd0, line_oe, line_out, busy, done, err, rx_data},
                    {19'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("postReset", {18'd0, lineW, line_oe, line_out, busy, done, err, rx_data},
                    {18'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/half_duplex_link.md
# half_duplex_link

- Serial transaction engine that drives and samples a single shared tri-state line.
- Data path:
  - Upstream of the line's tri-state buffer: supplies the buffer's data (`line_out`) and enable (`line_oe`).
  - Downstream of the resolved wire: reads it back on `line_in`.
- Transaction sequence: transmit one word, release the line for turnaround, then capture the response word from the far end.
- Sits between a simple request/done client and the bidirectional pin; the line is pulled high externally when nobody drives.

## Interface
- `DATA_W`, default 8: bits per word, both directions.
- `BIT_CYCLES`, default 4: clocks per bit; must be even and ≥ 2.
- `TURN_CYCLES`, default 2: clocks the line stays released between TX and RX.
- `TIMEOUT_BITS`, default 16: bit periods allowed for a response start bit before aborting.
- `clk` input 1: single clock, all logic rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a transaction; honoured only in IDLE.
- `tx_data` input DATA_W: word to send; captured on the accepting edge.
- `busy` output 1: high from the cycle after acceptance until `done`.
- `done` output 1: one-cycle pulse at transaction end.
- `err` output 1: valid with `done`; 1 = response timeout.
- `rx_data` output DATA_W: last successfully received word.
- `line_out` output 1: data to the tri-state buffer.
- `line_oe` output 1: buffer enable; 0 = line released (Z).
- `line_in` input 1: resolved line value; pull-up gives 1 when undriven.

## Operation
- States: IDLE, TX_START, TX_DATA, TURN, RX_WAIT, RX_START, RX_DATA, DONE.
- IDLE:
  - Outputs: `line_oe`=0, `busy`=0.
  - `start`=1 latches `tx_data` into the shift register and moves to TX_START.
- TX_START: `line_oe`=1, `line_out`=0 for BIT_CYCLES clocks.
- TX_DATA:
  - DATA_W bits, LSB first, BIT_CYCLES clocks each, `line_oe`=1.
  - After the last bit, go to TURN.
- TURN:
  - `line_oe`=0 for TURN_CYCLES clocks.
  - `line_in` is ignored.
- RX_WAIT:
  - `line_oe`=0; `line_in` is sampled each clock.
  - `line_in`=0 → RX_START.
  - Timeout counter reaching TIMEOUT_BITS×BIT_CYCLES clocks → DONE with `err`=1.
- RX_START:
  - Waits BIT_CYCLES/2 clocks, then re-samples `line_in`.
  - 0 → RX_DATA.
  - 1 → false start: back to RX_WAIT; the timeout counter is not reset.
- RX_DATA:
  - Samples DATA_W bits, LSB first, every BIT_CYCLES clocks, at mid-bit.
  - After the last sample, go to DONE.
- DONE:
  - One cycle.
  - `done`=1; `err`=0 on success, 1 on timeout.
  - On success, `rx_data` loads on the DONE edge. On timeout, `rx_data` is unchanged.
  - Returns to IDLE.
- `start` while not IDLE (including DONE) is ignored; no queuing.
- `line_in` X/Z in RX_WAIT or RX_DATA is treated as 1; the bench must use a pulled-up net.

## Timing
- Reset values: `line_oe`=0, `line_out`=1, `busy`=0, `done`=0, `err`=0, `rx_data`=0, state IDLE.
- Reset is asynchronous: asserting `rst_n` mid-transaction releases the line (`line_oe`=0) immediately, without waiting for `clk`.
- Acceptance on edge N:
  - `busy`=1, `line_oe`=1 and `line_out`=0 from edge N+1.
  - TX bit k (0-based) is driven from edge N+1+(k+1)×BIT_CYCLES.
  - `line_oe` falls at edge N+1+(DATA_W+1)×BIT_CYCLES.
- First RX_WAIT sample: TURN_CYCLES clocks after `line_oe` falls.
- RX sampling:
  - Bit j is sampled (j+1)×BIT_CYCLES clocks after the RX_START confirm.
  - `done` asserts the cycle after the last sample.
- `busy` falls on the same edge that `done` falls; `start` may be accepted on the very next edge.
- Bit-period, turnaround and timeout counters are wide enough for TIMEOUT_BITS×BIT_CYCLES with no wrap; they clear on every state entry except RX_WAIT re-entry.

## Structure
- Shared header `half_duplex_defs.vh`:
  - State encodings (3-bit localparams).
  - Default parameter values.
  - The line-idle level constant (1).
- Sub-module `bit_timer`:
  - Loadable down-counter with a `tick` output at terminal count.
  - Instanced once; reloaded for bit periods, half-bit, turnaround and timeout.
- Top level holds the FSM, the TX/RX shift registers, and the output registers (registered `line_out`/`line_oe`, glitch-free).

## Test plan
- Reset held, then released, no `start` → `line_oe`=0, `busy`=0, line reads 1 (Z plus pull-up) for 100 clocks.
- `tx_data`=8'hA5, responder answers 8'h3C after turnaround → line waveform 0,1,0,1,0,0,1,0,1 (BIT_CYCLES=4 each) then Z; `done` with `err`=0, `rx_data`=8'h3C.
- No responder → `done`, `err`=1 exactly 16×4 clocks after first RX_WAIT sample; `rx_data` retains previous 8'h3C.
- Responder glitches the line low for 1 clock, then sends 8'h81 → glitch rejected, `rx_data`=8'h81, `err`=0.
- `start` pulsed mid-TX with `tx_data`=8'hFF → ignored; the original word completes unchanged.
- `rst_n` asserted during TX_DATA bit 3 → `line_oe`=0 before the next `clk` edge; after release, IDLE with all outputs at reset values.
